// File: rtl/serial_pkg.sv
// serial_pkg
// Shared types and defaults for the serial frame receiver slice.
//   state_t        : receiver FSM state (HUNT / DATA / PARITY), 2-bit encoding
//   DEF_DATA_W     : default payload width
//   DEF_SYNC_W     : default sync pattern length
//   DEF_SYNC       : default sync pattern, first received bit is the MSB
//   calc_parity()  : reduction XOR of a (zero-extended) word

package serial_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int          DEF_DATA_W = 8;
    localparam int          DEF_SYNC_W = 4;
    localparam logic [3:0]  DEF_SYNC   = 4'b0011;

    // Zero-extension does not change the XOR, so narrower words can be
    // cast up to 32 bits before calling this.
    function automatic logic calc_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_sync_window.sv
// serial_sync_window
// Sliding sync-pattern detector used while the receiver is hunting.
// Ports:
//   clk      in  rising-edge clock
//   clr      in  asynchronous active-low reset
//   shift_en in  shift din into the window on this edge
//   flush    in  clear window and fill count on this edge
//   din      in  serial data bit
//   match    out combinational: the bit being shifted in completes the pattern
//                and the window (including this bit) is completely filled

module serial_sync_window #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b0011
) (
    input  logic clk,
    input  logic clr,
    input  logic shift_en,
    input  logic flush,
    input  logic din,
    output logic match
);

    localparam int FW = $clog2(SYNC_W + 1);

    logic [SYNC_W-1:0] window;
    logic [SYNC_W-1:0] window_next;
    logic [FW-1:0]     fill;

    assign window_next = {window[SYNC_W-2:0], din};

    // The fill count guards against a freshly cleared window of zeros
    // looking like the leading zeros of the pattern.
    assign match = shift_en
                && (window_next == SYNC)
                && (fill >= FW'(SYNC_W - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            window <= '0;
            fill   <= '0;
        end else if (flush) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= window_next;
            if (fill != FW'(SYNC_W))
                fill <= fill + FW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Hunts for a sync pattern in a serial bit stream, deserializes the next
// DATA_W bits MSB-first and optionally checks one even-parity bit.
// Ports:
//   clk        in  rising-edge clock
//   clr        in  asynchronous active-low reset
//   en         in  bit-sample qualifier; din consumed only when en=1
//   din        in  serial data
//   dout       out last completed payload, MSB = first payload bit received
//   dout_valid out one-cycle pulse when a frame completes
//   par_err    out parity mismatch for the completed frame (only with dout_valid)
//   locked     out high while in DATA or PARITY state

module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                SYNC_W    = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC      = DEF_SYNC,
    parameter int                PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              par_err,
    output logic              locked
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] payload_next;
    logic              last_bit;
    logic              frame_done;
    logic              match;

    assign payload_next = {payload[DATA_W-2:0], din};
    assign last_bit     = (bit_cnt == CW'(DATA_W - 1));

    // The completing edge: parity bit sampled, or last payload bit when no
    // parity bit is sent. Used to flush the sync window so payload bits can
    // never be mistaken for a sync.
    assign frame_done = en && ((state == PARITY)
                            || (state == DATA && last_bit && PARITY_EN == 0));

    serial_sync_window #(
        .SYNC_W (SYNC_W),
        .SYNC   (SYNC)
    ) u_sync (
        .clk      (clk),
        .clr      (clr),
        .shift_en (en && (state == HUNT)),
        .flush    (frame_done),
        .din      (din),
        .match    (match)
    );

    // Receiver FSM. dout_valid and par_err are single-cycle pulses, so they
    // drop on every edge and are re-raised only on a completing edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            payload    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            par_err    <= 1'b0;
            locked     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            par_err    <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        if (match) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            locked  <= 1'b1;
                        end
                    end
                    DATA: begin
                        payload <= payload_next;
                        if (last_bit) begin
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                            end else begin
                                dout       <= payload_next;
                                dout_valid <= 1'b1;
                                state      <= HUNT;
                                locked     <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        dout       <= payload;
                        dout_valid <= 1'b1;
                        par_err    <= din ^ calc_parity(32'(payload));
                        state      <= HUNT;
                        locked     <= 1'b0;
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Self-checking bench for serial_frame_rx (DATA_W=8, SYNC=0011, parity on).
// Directed frames first, then randomized frames, noise and resets. A
// behavioural model tracks the stream as a queue of recent bits plus a
// payload accumulator and predicts all outputs every cycle.

module tb_serial_frame_rx;

    localparam int         DW   = 8;
    localparam logic [3:0] SYNC = 4'b0011;

    logic          clk;
    logic          clr;
    logic          en;
    logic          din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          par_err;
    logic          locked;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    bit       hunt_q[$];
    int       model_mode;      // 0 hunting, 1 collecting payload, 2 awaiting parity
    int       model_nbits;
    int       model_pay;
    logic [DW-1:0] exp_dout;
    logic     exp_valid;
    logic     exp_err;
    logic     exp_locked;

    serial_frame_rx #(
        .DATA_W    (DW),
        .SYNC_W    (4),
        .SYNC      (SYNC),
        .PARITY_EN (1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .par_err    (par_err),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        hunt_q.delete();
        model_mode  = 0;
        model_nbits = 0;
        model_pay   = 0;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
        exp_locked  = 1'b0;
    endtask

    // One qualified-or-not clock edge of the intended behaviour.
    task automatic modelStep(input logic e, input logic d);
        logic [3:0] w;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!e) return;
        case (model_mode)
            0: begin
                hunt_q.push_back(d);
                if (hunt_q.size() > 4) void'(hunt_q.pop_front());
                if (hunt_q.size() == 4) begin
                    w = '0;
                    foreach (hunt_q[i]) w = {w[2:0], hunt_q[i]};
                    if (w == SYNC) begin
                        model_mode  = 1;
                        model_nbits = 0;
                        model_pay   = 0;
                        exp_locked  = 1'b1;
                    end
                end
            end
            1: begin
                model_pay = model_pay * 2 + int'(d);
                model_nbits++;
                if (model_nbits == DW) model_mode = 2;
            end
            default: begin
                exp_dout   = DW'(model_pay);
                exp_valid  = 1'b1;
                exp_err    = (($countones(DW'(model_pay)) + int'(d)) % 2) != 0;
                exp_locked = 1'b0;
                model_mode = 0;
                hunt_q.delete();
            end
        endcase
    endtask

    task automatic compareAll();
        checkOutput("dout",       32'(dout),       32'(exp_dout));
        checkOutput("dout_valid", 32'(dout_valid), 32'(exp_valid));
        checkOutput("par_err",    32'(par_err),    32'(exp_err));
        checkOutput("locked",     32'(locked),     32'(exp_locked));
    endtask

    // Called at a negative edge; returns at the next negative edge.
    task automatic applyStimulus(input logic e, input logic d);
        en  = e;
        din = d;
        @(posedge clk);
        modelStep(e, d);
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, bits[i]);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Low pulse of clr for one cycle, checked asynchronously.
    task automatic pulseReset();
        clr = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic sendFrameGapped(input logic [7:0] pay, input logic p, input int gap_pct);
        logic [12:0] bits;
        bits = {SYNC, pay, p};
        for (int i = 12; i >= 0; i--) begin
            while ($urandom_range(0, 99) < gap_pct) idleCycle();
            applyStimulus(1'b1, bits[i]);
        end
    endtask

    initial begin
        clr = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;

        // Basic frame, good parity
        sendBits(32'b0011, 4);
        sendBits(32'hA5, 8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_dout",  32'(dout),       32'hA5);
        checkOutput("t1_valid", 32'(dout_valid), 32'd1);
        checkOutput("t1_err",   32'(par_err),    32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_pulse", 32'(dout_valid), 32'd0);

        // Same frame, bad parity
        sendBits(32'b0011, 4);
        sendBits(32'hA5, 8);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t2_err",   32'(par_err),    32'd1);
        checkOutput("t2_dout",  32'(dout),       32'hA5);

        // Partial window must not match; lock on sixth bit
        pulseReset();
        sendBits(32'b11, 2);
        checkOutput("t3_nolock", 32'(locked), 32'd0);
        sendBits(32'b0011, 4);
        checkOutput("t3_lock",   32'(locked), 32'd1);
        sendBits(32'hFF, 8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_dout",   32'(dout),    32'hFF);
        checkOutput("t3_err",    32'(par_err), 32'd0);

        // en gaps inside the frame are transparent
        sendBits(32'b0011, 4);
        sendBits(32'hA, 4);
        repeat (3) idleCycle();
        sendBits(32'h5, 4);
        idleCycle();
        checkOutput("t4_locked", 32'(locked), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_dout",   32'(dout),       32'hA5);
        checkOutput("t4_valid",  32'(dout_valid), 32'd1);

        // Reset mid-frame discards the partial payload
        sendBits(32'b0011, 4);
        sendBits(32'b10100, 5);
        pulseReset();
        checkOutput("t5_dout0", 32'(dout), 32'd0);
        sendBits(32'b010, 3);
        sendBits(32'b0011, 4);
        sendBits(32'h3C, 8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_dout",  32'(dout), 32'h3C);

        // Back-to-back frames
        sendBits(32'b0011, 4);
        sendBits(32'h81, 8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6_dout1", 32'(dout), 32'h81);
        sendBits(32'b0011, 4);
        sendBits(32'h7E, 8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6_dout2",  32'(dout),       32'h7E);
        checkOutput("t6_valid2", 32'(dout_valid), 32'd1);

        // Randomized frames, noise, and occasional resets
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 12) begin
                sendFrameGapped(8'($urandom), 1'($urandom_range(0, 1)), 15);
            end else if (r < 19) begin
                repeat ($urandom_range(1, 6))
                    applyStimulus(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
            end else begin
                pulseReset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
